sprite_attr_shadow: RTL and testbench

Frame-coherent shadow store for sprite attribute writes, placed between the CPU bus and `sprite_datapath`. It captures every CPU write to sprite attribute space into a local shadow copy and does not forward it immediately. At each vertical-blank start it replays only the changed entries, one per cycle, onto the datapath's write port. Sprites therefore never tear mid-frame.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_addr_map.sv | 58 +++++
 rtl/sprite_attr_shadow.sv | 116 +++++++++++
 tb/tb_sprite_attr_shadow.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite attribute path: CPU-visible
// attribute addresses, default slot count and the shadow flush state.
package sprite_pkg;

    localparam logic [15:0] SPR_ATTR_BASE   = 16'h4FF0;
    localparam logic [15:0] SPR_POS_BASE    = 16'h5060;
    localparam logic [15:0] SPR_FLIP_ADDR   = 16'h5003;
    localparam int          NUM_SPRITES_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    // Two attribute bytes plus two position bytes per sprite, plus the global flip byte.
    function automatic int entry_count(input int num_sprites);
        return 4 * num_sprites + 1;
    endfunction

endpackage

// File: rtl/sprite_addr_map.sv
// Bidirectional mapping between CPU sprite addresses and shadow entry indices,
// shared by capture (address -> index) and replay (index -> address).
module sprite_addr_map
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DEF,
    parameter int IDX_W       = 6
) (
    input  logic [15:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] rev_idx,
    output logic [15:0]      rev_addr
);

    localparam logic [15:0]      SPAN16  = 16'(2 * NUM_SPRITES);
    localparam logic [IDX_W-1:0] SPAN    = IDX_W'(2 * NUM_SPRITES);
    localparam logic [IDX_W-1:0] FLIP_IX = IDX_W'(4 * NUM_SPRITES);

    logic [15:0] off_attr_s;
    logic [15:0] off_pos_s;

    // Offsets wrap to large values below each base, so one compare checks both bounds.
    assign off_attr_s = addr - SPR_ATTR_BASE;
    assign off_pos_s  = addr - SPR_POS_BASE;

    // Forward decode: CPU address to shadow entry.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        if (off_attr_s < SPAN16) begin
            hit = 1'b1;
            idx = off_attr_s[IDX_W-1:0];
        end else if (off_pos_s < SPAN16) begin
            hit = 1'b1;
            idx = SPAN + off_pos_s[IDX_W-1:0];
        end else if (addr == SPR_FLIP_ADDR) begin
            hit = 1'b1;
            idx = FLIP_IX;
        end else begin
            hit = 1'b0;
            idx = '0;
        end
    end

    // Reverse decode: shadow entry back to its datapath address.
    always_comb begin
        rev_addr = 16'h0000;
        if (rev_idx < SPAN) begin
            rev_addr = SPR_ATTR_BASE + {{(16-IDX_W){1'b0}}, rev_idx};
        end else if (rev_idx < FLIP_IX) begin
            rev_addr = SPR_POS_BASE + {{(16-IDX_W){1'b0}}, rev_idx - SPAN};
        end else begin
            rev_addr = SPR_FLIP_ADDR;
        end
    end

endmodule

// File: rtl/sprite_attr_shadow.sv
// Shadow store for sprite attribute writes: CPU writes land in a local copy and
// only the changed entries are replayed to the sprite datapath at vblank start.
module sprite_attr_shadow
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_wr_en,
    input  logic        vblank_start,
    output logic [15:0] spr_addr,
    output logic [7:0]  spr_din,
    output logic        spr_wr_en,
    output logic        busy,
    output logic        overrun
);

    localparam int               NUM_ENTRIES = entry_count(NUM_SPRITES);
    localparam int               IDX_W       = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);

    flush_state_e           state_r;
    logic [IDX_W-1:0]       scan_r;
    logic [7:0]             shadow_r [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] dirty_r;
    logic [15:0]            spr_addr_r;
    logic [7:0]             spr_din_r;
    logic                   spr_wr_en_r;
    logic                   busy_r;
    logic                   overrun_r;

    logic                   cap_hit_s;
    logic [IDX_W-1:0]       cap_idx_s;
    logic [15:0]            scan_addr_s;

    sprite_addr_map #(
        .NUM_SPRITES (NUM_SPRITES),
        .IDX_W       (IDX_W)
    ) u_map (
        .addr     (cpu_addr),
        .hit      (cap_hit_s),
        .idx      (cap_idx_s),
        .rev_idx  (scan_r),
        .rev_addr (scan_addr_s)
    );

    // Flush sequencer, replay output register and CPU capture into the shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            scan_r      <= '0;
            dirty_r     <= '0;
            spr_addr_r  <= 16'h0000;
            spr_din_r   <= 8'h00;
            spr_wr_en_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else begin
            spr_addr_r  <= 16'h0000;
            spr_din_r   <= 8'h00;
            spr_wr_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (vblank_start) begin
                        state_r <= FLUSH;
                        scan_r  <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (dirty_r[scan_r]) begin
                        spr_addr_r      <= scan_addr_s;
                        spr_din_r       <= shadow_r[scan_r];
                        spr_wr_en_r     <= 1'b1;
                        dirty_r[scan_r] <= 1'b0;
                    end
                    if (vblank_start) begin
                        overrun_r <= 1'b1;
                    end
                    if (scan_r == LAST_IDX) begin
                        state_r <= IDLE;
                        scan_r  <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        scan_r  <= scan_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    scan_r  <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
            // Placed after the flush clear so a same-cycle CPU write keeps the entry dirty.
            if (cpu_wr_en && cap_hit_s) begin
                shadow_r[cap_idx_s] <= cpu_din;
                dirty_r[cap_idx_s]  <= 1'b1;
            end
        end
    end

    assign spr_addr  = spr_addr_r;
    assign spr_din   = spr_din_r;
    assign spr_wr_en = spr_wr_en_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_sprite_attr_shadow.sv
// Directed bench for sprite_attr_shadow: single-write vector table plus
// hand-written flush sequences for the timing corner cases.
module tb_sprite_attr_shadow;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_din = 8'h00;
    logic        cpu_wr_en = 1'b0;
    logic        vblank_start = 1'b0;
    logic [15:0] spr_addr;
    logic [7:0]  spr_din;
    logic        spr_wr_en;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  din;
        int          exp_n;
        int          exp_lat;
    } vec_t;

    wr_t wr_q[$];
    int  busy_cnt = 0;
    int  busy_first = -1;
    int  busy_last = -1;
    int  idle_bad = 0;

    sprite_attr_shadow #(.NUM_SPRITES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_wr_en    (cpu_wr_en),
        .vblank_start (vblank_start),
        .spr_addr     (spr_addr),
        .spr_din      (spr_din),
        .spr_wr_en    (spr_wr_en),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Cycle label edge_cnt+1 names the period that ends at the next edge.
    always @(negedge clk) begin
        if (spr_wr_en) begin
            wr_q.push_back('{cyc: edge_cnt + 1, a: spr_addr, d: spr_din});
        end else if (spr_addr != 16'h0000 || spr_din != 8'h00) begin
            idle_bad++;
        end
        if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = edge_cnt + 1;
            busy_last = edge_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_din   = d;
        cpu_wr_en = 1'b1;
        tick(1);
        cpu_wr_en = 1'b0;
    endtask

    task automatic start_flush(output int t);
        wr_q.delete();
        busy_cnt   = 0;
        busy_first = -1;
        busy_last  = -1;
        t = edge_cnt + 1;
        vblank_start = 1'b1;
        tick(1);
        vblank_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && busy; i++) tick(1);
        check({name, "_done"}, 32'(busy), 32'd0);
        tick(2);
    endtask

    task automatic check_wr(input string name, input int i, input int cyc,
                            input logic [15:0] a, input logic [7:0] d);
        if (wr_q.size() > i) begin
            check({name, "_cyc"}, wr_q[i].cyc, cyc);
            check({name, "_addr"}, 32'(wr_q[i].a), 32'(a));
            check({name, "_data"}, 32'(wr_q[i].d), 32'(d));
        end else begin
            check({name, "_present"}, wr_q.size(), i + 1);
        end
    endtask

    vec_t vecs[10];

    initial begin
        int t;
        vecs[0] = '{16'h4FF0, 8'h11, 1, 2};
        vecs[1] = '{16'h4FFF, 8'h22, 1, 17};
        vecs[2] = '{16'h5060, 8'h33, 1, 18};
        vecs[3] = '{16'h506F, 8'h44, 1, 33};
        vecs[4] = '{16'h5003, 8'h55, 1, 34};
        vecs[5] = '{16'h5000, 8'h66, 0, 0};
        vecs[6] = '{16'h5070, 8'h77, 0, 0};
        vecs[7] = '{16'h4FEF, 8'h11, 0, 0};
        vecs[8] = '{16'h5004, 8'hAA, 0, 0};
        vecs[9] = '{16'h505F, 8'h99, 0, 0};

        // Reset and an empty flush
        tick(2);
        rst_n = 1'b1;
        check("rst_wr_en", 32'(spr_wr_en), 32'd0);
        check("rst_addr", 32'(spr_addr), 32'd0);
        check("rst_din", 32'(spr_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        start_flush(t);
        wait_done("empty");
        check("empty_busy_cnt", busy_cnt, 33);
        check("empty_busy_first", busy_first, t + 1);
        check("empty_busy_last", busy_last, t + 33);
        check("empty_writes", wr_q.size(), 0);

        // Two dirty entries, then a clean flush
        cpu_write(16'h4FF1, 8'h05);
        cpu_write(16'h5060, 8'h40);
        start_flush(t);
        wait_done("two");
        check("two_count", wr_q.size(), 2);
        check_wr("two_w0", 0, t + 3, 16'h4FF1, 8'h05);
        check_wr("two_w1", 1, t + 18, 16'h5060, 8'h40);
        start_flush(t);
        wait_done("clean");
        check("clean_count", wr_q.size(), 0);

        // Single-write map vectors, including misses just outside each range
        for (int i = 0; i < 10; i++) begin
            cpu_write(vecs[i].addr, vecs[i].din);
            start_flush(t);
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d_count", i), wr_q.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0) begin
                check_wr($sformatf("vec%0d", i), 0, t + vecs[i].exp_lat, vecs[i].addr, vecs[i].din);
            end
        end

        // Writes during a flush: unscanned flip replays now, scanned idx 0 waits
        start_flush(t);
        tick(4);
        cpu_write(16'h5003, 8'h01);
        cpu_write(16'h4FF0, 8'h22);
        wait_done("mid");
        check("mid_count", wr_q.size(), 1);
        check_wr("mid_flip", 0, t + 34, 16'h5003, 8'h01);
        start_flush(t);
        wait_done("mid_next");
        check("mid_next_count", wr_q.size(), 1);
        check_wr("mid_next_w", 0, t + 2, 16'h4FF0, 8'h22);

        // Same-cycle write to the entry being scanned
        cpu_write(16'h4FF3, 8'h07);
        start_flush(t);
        tick(3);
        cpu_write(16'h4FF3, 8'h33);
        wait_done("coll");
        check("coll_count", wr_q.size(), 1);
        check_wr("coll_old", 0, t + 5, 16'h4FF3, 8'h07);
        start_flush(t);
        wait_done("coll_next");
        check("coll_next_count", wr_q.size(), 1);
        check_wr("coll_new", 0, t + 5, 16'h4FF3, 8'h33);

        // vblank during a flush: no restart, sticky overrun
        check("pre_overrun", 32'(overrun), 32'd0);
        start_flush(t);
        tick(9);
        vblank_start = 1'b1;
        tick(1);
        vblank_start = 1'b0;
        wait_done("ovr");
        check("ovr_busy_cnt", busy_cnt, 33);
        check("ovr_busy_last", busy_last, t + 33);
        check("ovr_flag", 32'(overrun), 32'd1);

        // vblank on the last flush cycle is ignored as well
        start_flush(t);
        tick(32);
        vblank_start = 1'b1;
        tick(1);
        vblank_start = 1'b0;
        wait_done("last");
        check("last_busy_cnt", busy_cnt, 33);
        check("last_busy_after", 32'(busy), 32'd0);

        // Reset in the middle of a flush discards pending entries
        cpu_write(16'h4FF2, 8'h5A);
        cpu_write(16'h5061, 8'h6B);
        start_flush(t);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        check("mrst_wr_en", 32'(spr_wr_en), 32'd0);
        check("mrst_addr", 32'(spr_addr), 32'd0);
        check("mrst_din", 32'(spr_din), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        check_wr("mrst_pre", 0, t + 4, 16'h4FF2, 8'h5A);
        start_flush(t);
        wait_done("post");
        check("post_count", wr_q.size(), 0);
        check("post_busy_cnt", busy_cnt, 33);
        check("idle_outputs_zero", idle_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
